// File: rtl/emio_gpio_readback.sv
// emio_gpio_readback: coherent PL->PS status word over EMIO GPIO with request/ack toggle handshake (optional timestamp via EMIO_READBACK_TIMESTAMP_EN)
module emio_gpio_readback #(
  parameter int REQ_BIT     = 2,
  parameter int CLR_BIT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic [63:0] emio_gpio_o,
  output logic [63:0] emio_gpio_i
);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE, ACK} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] req_sync, clr_sync;
  logic req_d, clr_d, req_edge, clr_edge;
  logic cap_en, ack_en, ovr_set;
  logic [CW-1:0] cnt;
  logic [31:0] snapshot;
  logic [7:0] seq;
  logic [15:0] ts_snap;
  logic ack, busy, overrun;
  logic unused_gpio;
  assign unused_gpio = ^emio_gpio_o;
  assign req_edge = req_sync[SYNC_STAGES-1] ^ req_d;
  assign clr_edge = clr_sync[SYNC_STAGES-1] ^ clr_d;
  // bring the PS-side request/clear toggles into the fabric clock domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_sync <= '0;
      clr_sync <= '0;
      req_d    <= 1'b0;
      clr_d    <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], emio_gpio_o[REQ_BIT]};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], emio_gpio_o[CLR_BIT]};
      req_d    <= req_sync[SYNC_STAGES-1];
      clr_d    <= clr_sync[SYNC_STAGES-1];
    end
  end
  // handshake state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: capture waits for coherent data, settle holds the word before ack
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_edge ? CAPTURE : IDLE;
      CAPTURE: state_nx = data_valid ? SETTLE : CAPTURE;
      SETTLE:  state_nx = (cnt == '0) ? ACK : SETTLE;
      default: state_nx = IDLE;
    endcase
  end
  // strobes for the datapath; a request arriving while busy is dropped and flagged
  always_comb begin
    cap_en  = (state == CAPTURE) && data_valid;
    ack_en  = (state == ACK);
    ovr_set = req_edge && (state != IDLE);
  end
  // snapshot, sequence, settle counter, ack/busy/overrun flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snapshot <= '0;
      seq      <= '0;
      cnt      <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      if (cap_en) begin
        snapshot <= data_in;
        seq      <= seq + 8'd1;
        cnt      <= CW'(SETTLE_CYC - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (ack_en) ack <= ~ack;
      if (ovr_set) overrun <= 1'b1;
      else if (clr_edge) overrun <= 1'b0;
    end
  end
`ifdef EMIO_READBACK_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  // free-running cycle counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else ts_cnt <= ts_cnt + 16'd1;
  end
  // timestamp latched together with the snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) ts_snap <= '0;
    else if (cap_en) ts_snap <= ts_cnt;
  end
`else
  assign ts_snap = '0;
`endif
  assign emio_gpio_i = {ts_snap, seq, 5'b0, overrun, busy, ack, snapshot};
endmodule
